// File: rtl/lsu_nbload_ctl.sv
// lsu_nbload_ctl: tracks outstanding non-blocking loads in a small table.
// Each entry moves through FREE -> PEND -> READY -> FREE. A cancelled load
// parks in CANC until its data returns. READY entries are written back
// round-robin. Returns to FREE or READY entries raise a one-cycle proto_err.
//
// Optional feature: define RV_NBLOAD_WB_BYPASS_EN to forward a return to the
// writeback port in the same cycle. Forwarding happens only when no entry is
// READY and the returning tag is not being cancelled. The default build has
// no path from data_* to wb_*.
module lsu_nbload_ctl #(
    parameter int DEPTH = 4,
    parameter int TW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_valid,
    input  logic [4:0]    alloc_rd,
    output logic          alloc_ready,
    output logic [TW-1:0] alloc_tag,
    input  logic          data_valid,
    input  logic [TW-1:0] data_tag,
    input  logic [31:0]   data,
    input  logic          cancel_valid,
    input  logic [TW-1:0] cancel_tag,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [TW-1:0] wb_tag,
    output logic [4:0]    wb_rd,
    output logic [31:0]   wb_data,
    input  logic [4:0]    cam_rd,
    output logic          cam_hit,
    output logic          proto_err
);

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_CANC  = 2'd2,
        ST_READY = 2'd3
    } ent_state_t;

    ent_state_t    state_q [DEPTH];
    logic [4:0]    rd_q    [DEPTH];
    logic [31:0]   data_q  [DEPTH];
    logic [TW-1:0] rr_q;
    logic          hold_valid_q;
    logic [TW-1:0] hold_tag_q;
    logic          proto_err_q;

    logic          any_free;
    logic [TW-1:0] free_tag;
    logic          any_ready;
    logic [TW-1:0] rr_tag;
    logic [TW-1:0] rr_idx;
    logic          rr_found;
    logic [TW-1:0] grant_tag;
    logic          wb_valid_int;
    logic [TW-1:0] wb_tag_int;
    logic [4:0]    wb_rd_int;
    logic [31:0]   wb_data_int;
    logic          wb_fire;
    logic          alloc_fire;
    logic          cam_any;
`ifdef RV_NBLOAD_WB_BYPASS_EN
    logic          bypass;
`endif

    // Find the lowest-numbered FREE entry from registered state only.
    always_comb begin
        any_free = 1'b0;
        free_tag = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (state_q[i] == ST_FREE) begin
                any_free = 1'b1;
                free_tag = TW'(i);
            end
        end
    end

    // Round-robin search for a READY entry, starting at rr and wrapping upward.
    always_comb begin
        rr_found = 1'b0;
        rr_tag   = '0;
        rr_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rr_idx = rr_q + TW'(k);
            if (!rr_found && state_q[rr_idx] == ST_READY) begin
                rr_found = 1'b1;
                rr_tag   = rr_idx;
            end
        end
        any_ready = rr_found;
    end

    // Keep a stalled grant stable so a newly READY entry cannot steal the port.
    always_comb begin
        grant_tag = rr_tag;
        if (hold_valid_q && state_q[hold_tag_q] == ST_READY) begin
            grant_tag = hold_tag_q;
        end
    end

`ifdef RV_NBLOAD_WB_BYPASS_EN
    // Forward a return to a PEND entry when nothing else is waiting to write back.
    always_comb begin
        bypass = data_valid && (state_q[data_tag] == ST_PEND) && !any_ready &&
                 !(cancel_valid && cancel_tag == data_tag);
    end
`endif

    // Select what the writeback port presents this cycle.
    always_comb begin
        wb_valid_int = 1'b0;
        wb_tag_int   = '0;
        wb_rd_int    = '0;
        wb_data_int  = '0;
        if (any_ready) begin
            wb_valid_int = 1'b1;
            wb_tag_int   = grant_tag;
            wb_rd_int    = rd_q[grant_tag];
            wb_data_int  = data_q[grant_tag];
        end
`ifdef RV_NBLOAD_WB_BYPASS_EN
        if (bypass) begin
            wb_valid_int = 1'b1;
            wb_tag_int   = data_tag;
            wb_rd_int    = rd_q[data_tag];
            wb_data_int  = data;
        end
`endif
    end

    // Drive the ports, forcing the reset values while rst is high.
    always_comb begin
        wb_valid    = wb_valid_int && !rst;
        wb_tag      = wb_valid ? wb_tag_int  : '0;
        wb_rd       = wb_valid ? wb_rd_int   : '0;
        wb_data     = wb_valid ? wb_data_int : '0;
        wb_fire     = wb_valid && wb_ready;
        alloc_ready = any_free || rst;
        alloc_tag   = rst ? '0 : free_tag;
        alloc_fire  = alloc_valid && any_free && !rst;
        proto_err   = proto_err_q && !rst;
    end

    // Decode probe: a live (PEND or READY) entry targeting cam_rd; x0 never hits.
    always_comb begin
        cam_any = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((state_q[i] == ST_PEND || state_q[i] == ST_READY) && rd_q[i] == cam_rd) begin
                cam_any = 1'b1;
            end
        end
        cam_hit = cam_any && (cam_rd != 5'd0) && !rst;
    end

    // Per-entry state machine plus rr pointer, grant hold and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= ST_FREE;
            end
            rr_q         <= '0;
            hold_valid_q <= 1'b0;
            hold_tag_q   <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                unique case (state_q[i])
                    ST_FREE: begin
                        if (alloc_fire && free_tag == TW'(i)) begin
                            state_q[i] <= ST_PEND;
                            rd_q[i]    <= alloc_rd;
                        end
                    end
                    ST_PEND: begin
                        if (cancel_valid && cancel_tag == TW'(i)) begin
                            state_q[i] <= (data_valid && data_tag == TW'(i)) ? ST_FREE : ST_CANC;
                        end else if (data_valid && data_tag == TW'(i)) begin
                            data_q[i]  <= data;
                            state_q[i] <= (wb_fire && wb_tag == TW'(i)) ? ST_FREE : ST_READY;
                        end
                    end
                    ST_CANC: begin
                        if (data_valid && data_tag == TW'(i)) begin
                            state_q[i] <= ST_FREE;
                        end
                    end
                    ST_READY: begin
                        if ((cancel_valid && cancel_tag == TW'(i)) ||
                            (wb_fire && wb_tag == TW'(i))) begin
                            state_q[i] <= ST_FREE;
                        end
                    end
                    default: state_q[i] <= ST_FREE;
                endcase
            end
            if (wb_fire) begin
                rr_q <= wb_tag + TW'(1);
            end
            hold_valid_q <= wb_valid && !wb_ready && !(cancel_valid && cancel_tag == wb_tag);
            hold_tag_q   <= wb_tag;
            proto_err_q  <= data_valid &&
                            (state_q[data_tag] == ST_FREE || state_q[data_tag] == ST_READY);
        end
    end

endmodule

// File: tb/tb_lsu_nbload_ctl.sv
// Directed testbench for lsu_nbload_ctl (DEPTH=4). Honours
// RV_NBLOAD_WB_BYPASS_EN when the same macro is defined for the bench.
module tb_lsu_nbload_ctl;

    localparam int DEPTH = 4;
    localparam int TW    = 2;

    logic          clk;
    logic          rst;
    logic          alloc_valid;
    logic [4:0]    alloc_rd;
    logic          alloc_ready;
    logic [TW-1:0] alloc_tag;
    logic          data_valid;
    logic [TW-1:0] data_tag;
    logic [31:0]   data;
    logic          cancel_valid;
    logic [TW-1:0] cancel_tag;
    logic          wb_valid;
    logic          wb_ready;
    logic [TW-1:0] wb_tag;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic [4:0]    cam_rd;
    logic          cam_hit;
    logic          proto_err;

    int vectors     = 0;
    int miscompares = 0;

    lsu_nbload_ctl #(.DEPTH(DEPTH), .TW(TW)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .data_valid(data_valid), .data_tag(data_tag), .data(data),
        .cancel_valid(cancel_valid), .cancel_tag(cancel_tag),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .cam_rd(cam_rd), .cam_hit(cam_hit), .proto_err(proto_err)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change 1 ns after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Return data to a PEND entry with wb_ready=1 and watch it drain.
    task automatic returnAndDrain(input int tag, input logic [31:0] d, input int rd);
        data_valid = 1'b1;
        data_tag   = TW'(tag);
        data       = d;
        wb_ready   = 1'b1;
`ifdef RV_NBLOAD_WB_BYPASS_EN
        #1;
        checkOutput("byp_wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("byp_wb_tag",   32'(wb_tag),   32'(tag));
        checkOutput("byp_wb_rd",    32'(wb_rd),    32'(rd));
        checkOutput("byp_wb_data",  wb_data,       d);
        applyStimulus();
        data_valid = 1'b0;
        #1;
        checkOutput("byp_wb_done", 32'(wb_valid), 32'd0);
`else
        #1;
        checkOutput("ret_no_comb_wb", 32'(wb_valid), 32'd0);
        applyStimulus();
        data_valid = 1'b0;
        #1;
        checkOutput("wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("wb_tag",   32'(wb_tag),   32'(tag));
        checkOutput("wb_rd",    32'(wb_rd),    32'(rd));
        checkOutput("wb_data",  wb_data,       d);
        applyStimulus();
        #1;
        checkOutput("wb_done", 32'(wb_valid), 32'd0);
`endif
    endtask

    // Allocate one entry and check which tag it receives.
    task automatic allocOne(input int rd, input int exp_tag);
        alloc_valid = 1'b1;
        alloc_rd    = 5'(rd);
        #1;
        checkOutput("alloc_tag", 32'(alloc_tag), 32'(exp_tag));
        applyStimulus();
        alloc_valid = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        rst = 1'b1; alloc_valid = 1'b0; alloc_rd = '0; data_valid = 1'b0;
        data_tag = '0; data = '0; cancel_valid = 1'b0; cancel_tag = '0;
        wb_ready = 1'b0; cam_rd = 5'd5;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        checkOutput("rst_alloc_tag",   32'(alloc_tag),   32'd0);
        checkOutput("rst_wb_valid",    32'(wb_valid),    32'd0);
        checkOutput("rst_wb_data",     wb_data,          32'd0);
        checkOutput("rst_proto_err",   32'(proto_err),   32'd0);
        checkOutput("rst_cam_hit",     32'(cam_hit),     32'd0);
        rst = 1'b0;

        // Fill the table with rd 5..8.
        for (int i = 0; i < 4; i++) allocOne(5 + i, i);
        #1;
        checkOutput("full_alloc_ready", 32'(alloc_ready), 32'd0);
        cam_rd = 5'd6; #1;
        checkOutput("cam_hit_rd6", 32'(cam_hit), 32'd1);
        cam_rd = 5'd0; #1;
        checkOutput("cam_hit_rd0", 32'(cam_hit), 32'd0);
        cam_rd = 5'd9; #1;
        checkOutput("cam_miss_rd9", 32'(cam_hit), 32'd0);

        // Return tag 2; entry 2 frees after writeback, rr becomes 3.
        returnAndDrain(2, 32'hDEADBEEF, 7);
        checkOutput("freed_tag2", 32'(alloc_tag), 32'd2);
        // Return tag 1; rr becomes 2.
        returnAndDrain(1, 32'h0000_0011, 6);
        checkOutput("freed_tag1", 32'(alloc_tag), 32'd1);
        allocOne(9, 1);
        #1;
        checkOutput("next_free_tag2", 32'(alloc_tag), 32'd2);

        // Make 3, 0, 1 READY under back-pressure, then drain: expect 3,0,1.
        wb_ready = 1'b0;
        data_valid = 1'b1; data_tag = 2'd3; data = 32'hA3A3_A3A3;
        applyStimulus();
        data_tag = 2'd0; data = 32'hA0A0_A0A0; #1;
        checkOutput("rr_first_valid", 32'(wb_valid), 32'd1);
        checkOutput("rr_first_tag",   32'(wb_tag),   32'd3);
        checkOutput("rr_first_rd",    32'(wb_rd),    32'd8);
        checkOutput("rr_first_data",  wb_data,       32'hA3A3_A3A3);
        applyStimulus();
        data_tag = 2'd1; data = 32'hA1A1_A1A1; #1;
        checkOutput("stall_tag_a", 32'(wb_tag), 32'd3);
        applyStimulus();
        data_valid = 1'b0; #1;
        checkOutput("stall_tag_b",   32'(wb_tag),  32'd3);
        checkOutput("cam_hit_ready", 32'(cam_hit), 32'd1);
        wb_ready = 1'b1; #1;
        checkOutput("grant_3", 32'(wb_tag), 32'd3);
        applyStimulus();
        checkOutput("grant_0",      32'(wb_tag), 32'd0);
        checkOutput("grant_0_rd",   32'(wb_rd),  32'd5);
        checkOutput("grant_0_data", wb_data,     32'hA0A0_A0A0);
        applyStimulus();
        checkOutput("grant_1",      32'(wb_tag), 32'd1);
        checkOutput("grant_1_rd",   32'(wb_rd),  32'd9);
        checkOutput("grant_1_data", wb_data,     32'hA1A1_A1A1);
        applyStimulus();
        checkOutput("drained_valid", 32'(wb_valid), 32'd0);
        checkOutput("drained_tag",   32'(alloc_tag), 32'd0);

        // Cancel a PEND entry, then return to it twice.
        allocOne(10, 0);
        allocOne(11, 1);
        cancel_valid = 1'b1; cancel_tag = 2'd1;
        applyStimulus();
        cancel_valid = 1'b0; cam_rd = 5'd11; #1;
        checkOutput("cam_canc_miss", 32'(cam_hit), 32'd0);
        cam_rd = 5'd10; #1;
        checkOutput("cam_pend_hit", 32'(cam_hit), 32'd1);
        data_valid = 1'b1; data_tag = 2'd1; data = 32'h0BAD_0001;
        applyStimulus();
        data_valid = 1'b0; #1;
        checkOutput("canc_ret_wb",    32'(wb_valid),  32'd0);
        checkOutput("canc_ret_proto", 32'(proto_err), 32'd0);
        checkOutput("canc_ret_freed", 32'(alloc_tag), 32'd1);
        data_valid = 1'b1; data_tag = 2'd1;
        applyStimulus();
        data_valid = 1'b0; #1;
        checkOutput("free_ret_proto", 32'(proto_err), 32'd1);
        applyStimulus();
        checkOutput("proto_pulse_end", 32'(proto_err), 32'd0);

        // Same-cycle return and cancel on PEND tag 0.
        data_valid = 1'b1; data_tag = 2'd0; data = 32'hC0C0_C0C0;
        cancel_valid = 1'b1; cancel_tag = 2'd0; wb_ready = 1'b1;
        applyStimulus();
        data_valid = 1'b0; cancel_valid = 1'b0; #1;
        checkOutput("rc_wb_valid",  32'(wb_valid),  32'd0);
        checkOutput("rc_alloc_tag", 32'(alloc_tag), 32'd0);
        checkOutput("rc_proto",     32'(proto_err), 32'd0);
        checkOutput("rc_cam",       32'(cam_hit),   32'd0);

        // Cancel coinciding with the writeback handshake on a READY entry.
        allocOne(4, 0);
        wb_ready = 1'b0;
        data_valid = 1'b1; data_tag = 2'd0; data = 32'h0000_00C4;
        applyStimulus();
        data_valid = 1'b0; #1;
        checkOutput("cw_ready_tag", 32'(wb_tag), 32'd0);
        cancel_valid = 1'b1; cancel_tag = 2'd0; wb_ready = 1'b1;
        applyStimulus();
        cancel_valid = 1'b0; #1;
        checkOutput("cw_wb_valid",  32'(wb_valid),  32'd0);
        checkOutput("cw_alloc_tag", 32'(alloc_tag), 32'd0);

        // Reset in the middle of activity discards everything.
        allocOne(1, 0);
        allocOne(2, 1);
        allocOne(3, 2);
        wb_ready = 1'b0;
        data_valid = 1'b1; data_tag = 2'd1; data = 32'h0000_0D01;
        applyStimulus();
        data_valid = 1'b0; #1;
        checkOutput("pre_rst_wb", 32'(wb_valid), 32'd1);
        rst = 1'b1; #1;
        checkOutput("in_rst_wb",        32'(wb_valid),    32'd0);
        checkOutput("in_rst_alloc_tag", 32'(alloc_tag),   32'd0);
        applyStimulus();
        rst = 1'b0; cam_rd = 5'd2; #1;
        checkOutput("post_rst_ready", 32'(alloc_ready), 32'd1);
        checkOutput("post_rst_tag",   32'(alloc_tag),   32'd0);
        checkOutput("post_rst_wb",    32'(wb_valid),    32'd0);
        checkOutput("post_rst_cam",   32'(cam_hit),     32'd0);

`ifdef RV_NBLOAD_WB_BYPASS_EN
        // Same-cycle forwarding of a return with nothing else READY.
        allocOne(20, 0);
        data_valid = 1'b1; data_tag = 2'd0; data = 32'h1234_5678; wb_ready = 1'b1; #1;
        checkOutput("bypass_valid", 32'(wb_valid), 32'd1);
        checkOutput("bypass_data",  wb_data,       32'h1234_5678);
        applyStimulus();
        data_valid = 1'b0; #1;
        checkOutput("bypass_freed", 32'(alloc_tag), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
